// File: rtl/mult_signed_seq.sv
// Iterative shift-add multiplier, signed or unsigned per operation.
// One partial product per clock; exact 2*WIDTH-bit product with a valid/busy handshake.
module mult_signed_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 sign_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int AW = 2*WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH:0]  a_ext;
    logic [WIDTH:0]  b_ext;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   term;
    logic [AW-1:0]   acc_next;
    logic [CW-1:0]   cnt;

    // The extended sign bit of b carries weight -2^WIDTH, so the last step subtracts.
    always_comb begin
        term     = {{(AW-WIDTH-1){a_ext[WIDTH]}}, a_ext} << cnt;
        acc_next = acc;
        if (b_ext[cnt]) begin
            acc_next = (cnt == LAST) ? acc - term : acc + term;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            prod      <= '0;
            acc       <= '0;
            a_ext     <= '0;
            b_ext     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (in_valid) begin
                        a_ext <= {sign_mode & a[WIDTH-1], a};
                        b_ext <= {sign_mode & b[WIDTH-1], b};
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (cnt == LAST) begin
                        prod      <= acc_next[2*WIDTH-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_signed_seq.sv
// Scoreboard bench for mult_signed_seq at WIDTH=8 and WIDTH=3.
// Drivers push expected products with their due cycle; negedge monitors compare.
module tb_mult_signed_seq;

    typedef struct {
        longint prod;
        int     due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid8 = 1'b0, sm8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, ov8;
    logic [15:0] prod8;

    logic       in_valid3 = 1'b0, sm3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       busy3, ov3;
    logic [5:0] prod3;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t q8[$];
    exp_t q3[$];
    int   nf8 = 0, nf3 = 0;
    int   lk8 = -100, lk3 = -100;
    longint hold8 = 0, hold3 = 0;
    int   acc8 = 0, acc3 = 0;
    int   seen8 = 0, seen3 = 0;

    mult_signed_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .sign_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .out_valid(ov8), .prod(prod8)
    );

    mult_signed_seq #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .sign_mode(sm3),
        .a(a3), .b(b3), .busy(busy3), .out_valid(ov3), .prod(prod3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic longint ref_prod(input int w, input bit sm, input longint av_in, input longint bv_in);
        longint m, av, bv;
        m  = (longint'(1) << w) - 1;
        av = av_in & m;
        bv = bv_in & m;
        if (sm && av[w-1]) av = av - (longint'(1) << w);
        if (sm && bv[w-1]) bv = bv - (longint'(1) << w);
        return (av * bv) & ((longint'(1) << (2*w)) - 1);
    endfunction

    // Inputs change 2 time units after a rising edge; acceptance follows the
    // issue-interval rule: request at edge e accepted iff the unit is idle by then.
    task automatic drive8(input bit v, input bit sm, input logic [7:0] av, input logic [7:0] bv,
                          input bit use_exp, input longint ex);
        exp_t e;
        @(posedge clk);
        #2;
        in_valid8 = v; sm8 = sm; a8 = av; b8 = bv;
        if (v && (cyc + 1) >= nf8) begin
            e.prod = use_exp ? ex : ref_prod(8, sm, longint'(av), longint'(bv));
            e.due  = cyc + 1 + 9;
            q8.push_back(e);
            nf8 = cyc + 1 + 11;
            lk8 = cyc + 1;
            acc8++;
        end
    endtask

    task automatic drive3(input bit v, input bit sm, input logic [2:0] av, input logic [2:0] bv,
                          input bit use_exp, input longint ex);
        exp_t e;
        @(posedge clk);
        #2;
        in_valid3 = v; sm3 = sm; a3 = av; b3 = bv;
        if (v && (cyc + 1) >= nf3) begin
            e.prod = use_exp ? ex : ref_prod(3, sm, longint'(av), longint'(bv));
            e.due  = cyc + 1 + 4;
            q3.push_back(e);
            nf3 = cyc + 1 + 6;
            lk3 = cyc + 1;
            acc3++;
        end
    endtask

    task automatic op8(input bit sm, input logic [7:0] av, input logic [7:0] bv, input longint ex);
        drive8(1'b1, sm, av, bv, 1'b1, ex);
        repeat (10) drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 0);
    endtask

    task automatic op3(input bit sm, input logic [2:0] av, input logic [2:0] bv, input bit use_exp, input longint ex);
        drive3(1'b1, sm, av, bv, use_exp, ex);
        repeat (5) drive3(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 0);
    endtask

    always @(negedge clk) begin
        bit exp_ov;
        exp_t e;
        exp_ov = (q8.size() > 0) && (q8[0].due == cyc);
        chk("out_valid8", longint'(ov8), longint'(exp_ov));
        if (ov8) seen8++;
        if (exp_ov) begin
            e = q8.pop_front();
            chk("prod8", longint'(prod8), e.prod);
            hold8 = e.prod;
        end else begin
            chk("prod8_hold", longint'(prod8), hold8);
        end
        chk("busy8", longint'(busy8), longint'((cyc >= lk8) && (cyc <= lk8 + 9)));
    end

    always @(negedge clk) begin
        bit exp_ov;
        exp_t e;
        exp_ov = (q3.size() > 0) && (q3[0].due == cyc);
        chk("out_valid3", longint'(ov3), longint'(exp_ov));
        if (ov3) seen3++;
        if (exp_ov) begin
            e = q3.pop_front();
            chk("prod3", longint'(prod3), e.prod);
            hold3 = e.prod;
        end else begin
            chk("prod3_hold", longint'(prod3), hold3);
        end
        chk("busy3", longint'(busy3), longint'((cyc >= lk3) && (cyc <= lk3 + 4)));
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy8", longint'(busy8), 0);
        chk("rst_ov8", longint'(ov8), 0);
        chk("rst_prod8", longint'(prod8), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Directed WIDTH=8 cases with hand-derived products.
        op8(1'b1, 8'hFD, 8'h05, 64'hFFF1);
        op8(1'b1, 8'h80, 8'h80, 64'h4000);
        op8(1'b0, 8'h80, 8'h80, 64'h4000);
        op8(1'b0, 8'hFF, 8'hFF, 64'hFE01);
        op8(1'b1, 8'hFF, 8'hFF, 64'h0001);
        op8(1'b1, 8'h00, 8'h9C, 64'h0000);
        op8(1'b0, 8'h7F, 8'h80, 64'h3F80);

        // Continuous request with changing operands.
        for (int i = 0; i < 60; i++)
            drive8(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0, 0);
        repeat (12) drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 0);

        // Asynchronous reset between edges, mid-calculation.
        drive8(1'b1, 1'b1, 8'h12, 8'hB4, 1'b0, 0);
        repeat (4) drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        acc8 = acc8 - q8.size();
        q8.delete();
        nf8 = 0; lk8 = -100; hold8 = 0;
        #1;
        chk("arst_busy8", longint'(busy8), 0);
        chk("arst_ov8", longint'(ov8), 0);
        chk("arst_prod8", longint'(prod8), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        op8(1'b1, 8'hF9, 8'h07, 64'hFFCF);

        // Random sweep at WIDTH=8 with random request gaps.
        for (int i = 0; i < 30000; i++)
            drive8(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   8'($urandom), 8'($urandom), 1'b0, 0);
        repeat (12) drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 0);

        // WIDTH=3 directed then exhaustive in both modes.
        op3(1'b1, 3'b100, 3'b100, 1'b1, 64'h10);
        op3(1'b1, 3'b100, 3'b011, 1'b1, 64'h34);
        op3(1'b1, 3'b111, 3'b001, 1'b1, 64'h3F);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                for (int s = 0; s < 2; s++)
                    op3(1'(s), 3'(i), 3'(j), 1'b0, 0);
        repeat (4) drive3(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 0);

        @(negedge clk);
        chk("q8_drained", longint'(q8.size()), 0);
        chk("q3_drained", longint'(q3.size()), 0);
        chk("count8", longint'(seen8), longint'(acc8));
        chk("count3", longint'(seen3), longint'(acc3));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
